// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID register.
// Latency: an instruction acked in cycle N is in IF/ID after edge N; one per cycle at zero wait.
// Backpressure: a stall freezes IF/ID and pc, parking any in-flight ack in a one-entry hold buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  BranchCtrl,
  input  logic [31:0] pc_imm,
  input  logic [31:0] pc_reg,
  input  logic        Flush,
  input  logic        IFID_RegWrite,
  input  logic        PCWrite,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_inst,
  output logic        IFID_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        vld;
  } ifid_t;

  state_t      state, state_nxt;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr, drain_addr_d;
  logic [31:0] hold_inst, hold_pc;
  logic        hold_vld, hold_vld_d, hold_load;

  logic        redirect, fetch_hit, avail, advance;
  logic [31:0] target, dat_pc, dat_inst;

  // Flush always accompanies a non-zero BranchCtrl, so redirect alone drives the bubble.
  logic        flush_unused;
  assign flush_unused = Flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (redirect && imem_req && !imem_ack) state_nxt = DRAIN;
      DRAIN:   if (imem_ack) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state == DRAIN) || ((state == FETCH) && !hold_vld);
    imem_addr = (state == DRAIN) ? drain_addr : pc_q;
  end

  assign redirect  = |BranchCtrl;
  assign target    = (BranchCtrl == 2'b10) ? (pc_reg & ~32'h1) : pc_imm;
  assign fetch_hit = (state == FETCH) && imem_req && imem_ack;
  assign avail     = fetch_hit || hold_vld;
  assign dat_pc    = hold_vld ? hold_pc   : pc_q;
  assign dat_inst  = hold_vld ? hold_inst : imem_rdata;
  assign advance   = IFID_RegWrite && PCWrite;

  always_comb begin
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    hold_vld_d   = hold_vld;
    drain_addr_d = drain_addr;
    hold_load    = 1'b0;
    if (redirect) begin
      pc_d       = target;
      hold_vld_d = 1'b0;
      // In DRAIN the IF/ID bubble is already in place; only the target moves.
      if (state != DRAIN) ifid_d = {pc_q, NOP_INST, 1'b0};
      if ((state == FETCH) && imem_req && !imem_ack) drain_addr_d = pc_q;
    end else if (advance) begin
      if (avail) begin
        ifid_d     = {dat_pc, dat_inst, 1'b1};
        pc_d       = dat_pc + 32'd4;
        hold_vld_d = 1'b0;
      end else begin
        ifid_d = {pc_q, NOP_INST, 1'b0};
      end
    end else if (fetch_hit) begin
      hold_load  = 1'b1;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drain_addr <= '0;
      hold_vld   <= 1'b0;
      hold_inst  <= '0;
      hold_pc    <= '0;
      ifid_q     <= {32'h0, NOP_INST, 1'b0};
    end else begin
      pc_q       <= pc_d;
      drain_addr <= drain_addr_d;
      hold_vld   <= hold_vld_d;
      ifid_q     <= ifid_d;
      if (hold_load) begin
        hold_inst <= imem_rdata;
        hold_pc   <= pc_q;
      end
    end
  end

  assign IFID_pc    = ifid_q.pc;
  assign IFID_inst  = ifid_q.inst;
  assign IFID_valid = ifid_q.vld;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int F_REQ = 0, F_ADDR = 1, F_PC = 2, F_INST = 3, F_VLD = 4;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  BranchCtrl;
  logic [31:0] pc_imm, pc_reg;
  logic        Flush, IFID_RegWrite, PCWrite;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, IFID_pc, IFID_inst;
  logic        IFID_valid;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns address-derived words; zero-wait mode acks whatever is requested.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;
  assign Flush      = |BranchCtrl;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .BranchCtrl(BranchCtrl), .pc_imm(pc_imm), .pc_reg(pc_reg),
    .Flush(Flush), .IFID_RegWrite(IFID_RegWrite), .PCWrite(PCWrite),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .IFID_pc(IFID_pc), .IFID_inst(IFID_inst), .IFID_valid(IFID_valid)
  );

  task automatic push(input string n, input int f, input logic [31:0] v);
    exp_t x;
    x.cyc = cyc; x.fld = f; x.val = v; x.name = n;
    q.push_back(x);
  endtask

  task automatic expect_cyc(input string n, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc, input logic [31:0] inst);
    push({n, ".req"}, F_REQ, {31'h0, req});
    if (req) push({n, ".addr"}, F_ADDR, addr);
    push({n, ".vld"}, F_VLD, {31'h0, vld});
    push({n, ".pc"}, F_PC, pc);
    push({n, ".inst"}, F_INST, inst);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.fld)
        F_REQ:   act = {31'h0, imem_req};
        F_ADDR:  act = imem_addr;
        F_PC:    act = IFID_pc;
        F_INST:  act = IFID_inst;
        default: act = {31'h0, IFID_valid};
      endcase
      checks = checks + 1;
      if (e.cyc != cyc || act !== e.val) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; BranchCtrl = 2'b00; pc_imm = '0; pc_reg = '0;
    IFID_RegWrite = 1'b1; PCWrite = 1'b1;
    #2 rst_n = 1'b0;

    step; expect_cyc("rst", 0, 0, 0, 0, NOP);
    step; rst_n = 1'b1; auto_ack = 1'b1; expect_cyc("boot", 0, 0, 0, 0, NOP);
    step; expect_cyc("f0", 1, 32'h0, 0, 32'h0, NOP);
    step; expect_cyc("f4", 1, 32'h4, 1, 32'h0, 32'hC0DE_0000);
    step; expect_cyc("f8", 1, 32'h8, 1, 32'h4, 32'hC0DE_0004);
    step; expect_cyc("fC", 1, 32'hC, 1, 32'h8, 32'hC0DE_0008);
    // three-cycle ack delay at 0x10
    step; auto_ack = 1'b0; expect_cyc("w10a", 1, 32'h10, 1, 32'hC, 32'hC0DE_000C);
    step; expect_cyc("w10b", 1, 32'h10, 0, 32'h10, NOP);
    step; expect_cyc("w10c", 1, 32'h10, 0, 32'h10, NOP);
    step; man_ack = 1'b1; expect_cyc("w10d", 1, 32'h10, 0, 32'h10, NOP);
    step; man_ack = 1'b0; auto_ack = 1'b1; expect_cyc("f14", 1, 32'h14, 1, 32'h10, 32'hC0DE_0010);
    step; expect_cyc("f18", 1, 32'h18, 1, 32'h14, 32'hC0DE_0014);
    step; expect_cyc("f1C", 1, 32'h1C, 1, 32'h18, 32'hC0DE_0018);
    // load-use stall while 0x20 is acked
    step; IFID_RegWrite = 1'b0; PCWrite = 1'b0; expect_cyc("stall", 1, 32'h20, 1, 32'h1C, 32'hC0DE_001C);
    step; IFID_RegWrite = 1'b1; PCWrite = 1'b1; expect_cyc("held", 0, 0, 1, 32'h1C, 32'hC0DE_001C);
    step; expect_cyc("f24", 1, 32'h24, 1, 32'h20, 32'hC0DE_0020);
    step; expect_cyc("f28", 1, 32'h28, 1, 32'h24, 32'hC0DE_0024);
    step; expect_cyc("f2C", 1, 32'h2C, 1, 32'h28, 32'hC0DE_0028);
    // branch while 0x30 is outstanding -> drain
    step; auto_ack = 1'b0; BranchCtrl = 2'b01; pc_imm = 32'h100;
          expect_cyc("br", 1, 32'h30, 1, 32'h2C, 32'hC0DE_002C);
    step; BranchCtrl = 2'b00; expect_cyc("drain1", 1, 32'h30, 0, 32'h30, NOP);
    step; man_ack = 1'b1; expect_cyc("drain2", 1, 32'h30, 0, 32'h100, NOP);
    step; man_ack = 1'b0; auto_ack = 1'b1; expect_cyc("f100", 1, 32'h100, 0, 32'h100, NOP);
    // jalr with same-cycle ack; low target bit cleared
    step; BranchCtrl = 2'b10; pc_reg = 32'h205; expect_cyc("jalr", 1, 32'h104, 1, 32'h100, 32'hC0DE_0100);
    step; BranchCtrl = 2'b00; expect_cyc("f204", 1, 32'h204, 0, 32'h104, NOP);
    step; BranchCtrl = 2'b01; pc_imm = 32'h40; expect_cyc("br40", 1, 32'h208, 1, 32'h204, 32'hC0DE_0204);
    step; BranchCtrl = 2'b00; auto_ack = 1'b0; expect_cyc("w40", 1, 32'h40, 0, 32'h208, NOP);
    // reset mid-request, late ack during BOOT
    step; rst_n = 1'b0; man_ack = 1'b1; expect_cyc("rstmid", 0, 0, 0, 0, NOP);
    step; rst_n = 1'b1; expect_cyc("boot2", 0, 0, 0, 0, NOP);
    step; man_ack = 1'b0; auto_ack = 1'b1; expect_cyc("rpc", 1, 32'h0, 0, 32'h0, NOP);
    // pc wrap at the top of the address space
    step; BranchCtrl = 2'b01; pc_imm = 32'hFFFF_FFFC; expect_cyc("f4b", 1, 32'h4, 1, 32'h0, 32'hC0DE_0000);
    step; BranchCtrl = 2'b00; expect_cyc("fwrap", 1, 32'hFFFF_FFFC, 0, 32'h4, NOP);
    // IFID_RegWrite/PCWrite disagreeing behaves as a stall
    step; PCWrite = 1'b0; expect_cyc("w0", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h3F21_FFFC);
    step; PCWrite = 1'b1; expect_cyc("hold0", 0, 0, 1, 32'hFFFF_FFFC, 32'h3F21_FFFC);
    step; expect_cyc("f4c", 1, 32'h4, 1, 32'h0, 32'hC0DE_0000);

    step; step;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain_queue left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
